// File: rtl/interval_timer.sv
// ----------------------------------------------------------------------------
// interval_timer
//   Programmable interval timer driven by the control unit. A write of a
//   non-zero value loads the timer and starts counting down one tick every
//   PRESCALE clock cycles. When the count expires, a sticky timeout flag is
//   raised and held until the control unit acknowledges it or reloads the
//   timer. Writing zero disables the timer.
//
//   Parameters
//     PRESCALE    : clk cycles per timer tick (1..255)
//     AUTO_RELOAD : 1 = reload and keep counting after expiry, 0 = one-shot
//
//   Ports
//     clk       in   system clock, rising-edge active
//     reset     in   asynchronous active-high reset
//     timer_in  in   load strobe, samples bus_in
//     bus_in    in   16-bit load value (0 disables the timer)
//     timer_ack in   clears a pending timeout
//     timeout   out  registered expiry flag
//     count     out  ticks remaining (registered)
//     running   out  high while counting
// ----------------------------------------------------------------------------
module interval_timer #(
    parameter int unsigned PRESCALE    = 12,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_in,
    input  logic [15:0] bus_in,
    input  logic        timer_ack,
    output logic        timeout,
    output logic [15:0] count,
    output logic        running
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    state_t      state_r;
    logic [15:0] count_r;
    logic [15:0] reload_r;
    logic [7:0]  presc_r;
    logic        timeout_r;
    logic        running_r;

    logic        tick_s;
    logic        expire_s;

    // Tick and expiry decode from the current prescaler and count.
    always_comb begin
        tick_s   = 1'b0;
        expire_s = 1'b0;
        if (state_r == ST_RUN) begin
            tick_s = (presc_r == PRESC_LAST);
            // count is never 0 in RUN; <=1 keeps the decrement from wrapping
            expire_s = tick_s && (count_r <= 16'd1);
        end else begin
            tick_s   = 1'b0;
            expire_s = 1'b0;
        end
    end

    // Timer state machine with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            count_r   <= 16'd0;
            reload_r  <= 16'd0;
            presc_r   <= 8'd0;
            timeout_r <= 1'b0;
            running_r <= 1'b0;
        end else if (timer_in) begin
            // A load overrides any simultaneous ack or expiry tick.
            presc_r   <= 8'd0;
            timeout_r <= 1'b0;
            if (bus_in != 16'd0) begin
                count_r   <= bus_in;
                reload_r  <= bus_in;
                state_r   <= ST_RUN;
                running_r <= 1'b1;
            end else begin
                count_r   <= 16'd0;
                reload_r  <= 16'd0;
                state_r   <= ST_IDLE;
                running_r <= 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (timer_ack) begin
                        timeout_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        presc_r <= 8'd0;
                    end else begin
                        presc_r <= presc_r + 8'd1;
                    end
                    if (expire_s) begin
                        // A fresh expiry beats a simultaneous ack.
                        timeout_r <= 1'b1;
                        if (AUTO_RELOAD) begin
                            count_r <= reload_r;
                        end else begin
                            count_r   <= 16'd0;
                            state_r   <= ST_EXPIRED;
                            running_r <= 1'b0;
                        end
                    end else begin
                        if (tick_s) begin
                            count_r <= count_r - 16'd1;
                        end
                        if (timer_ack) begin
                            timeout_r <= 1'b0;
                        end
                    end
                end
                ST_EXPIRED: begin
                    count_r <= 16'd0;
                    presc_r <= 8'd0;
                    if (timer_ack) begin
                        timeout_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    count_r   <= 16'd0;
                    reload_r  <= 16'd0;
                    presc_r   <= 8'd0;
                    timeout_r <= 1'b0;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    assign timeout = timeout_r;
    assign count   = count_r;
    assign running = running_r;

endmodule

// File: tb/tb_interval_timer.sv
// ----------------------------------------------------------------------------
// tb_interval_timer
//   Two timer instances share one stimulus stream: dut0 is a one-shot timer
//   with PRESCALE=12, dut1 an auto-reload timer with PRESCALE=2. Each edge is
//   checked against a time-based reference model (expiry and count derived
//   from the load edge with plain arithmetic), plus a constant vector table
//   and hand-written corner-case sequences.
// ----------------------------------------------------------------------------
module tb_interval_timer;

    logic        clk;
    logic        reset;
    logic        timer_in;
    logic [15:0] bus_in;
    logic        timer_ack;
    logic        to0, to1, run0, run1;
    logic [15:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    interval_timer #(.PRESCALE(12), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .timer_in(timer_in), .bus_in(bus_in),
        .timer_ack(timer_ack), .timeout(to0), .count(cnt0), .running(run0)
    );

    interval_timer #(.PRESCALE(2), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .timer_in(timer_in), .bus_in(bus_in),
        .timer_ack(timer_ack), .timeout(to1), .count(cnt1), .running(run1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a loaded timer is described by its load edge and value.
    longint m_p[2]  = '{12, 2};
    bit     m_ar[2] = '{1'b0, 1'b1};
    bit     m_act[2];
    bit     m_to[2];
    longint m_n[2];
    longint m_t0[2];
    longint edge_n = 0;

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0;
            m_to[d]  = 1'b0;
            m_n[d]   = 0;
            m_t0[d]  = 0;
        end
    endfunction

    function automatic void model_edge(input bit tin, input logic [15:0] bus, input bit ack);
        edge_n++;
        for (int d = 0; d < 2; d++) begin
            bit     fire;
            longint el;
            longint per;
            fire = 1'b0;
            if (tin) begin
                m_to[d] = 1'b0;
                if (bus != 16'd0) begin
                    m_act[d] = 1'b1;
                    m_n[d]   = longint'(bus);
                    m_t0[d]  = edge_n;
                end else begin
                    m_act[d] = 1'b0;
                end
            end else begin
                el  = edge_n - m_t0[d];
                per = m_n[d] * m_p[d];
                if (m_act[d]) begin
                    if (m_ar[d]) begin
                        fire = (el % per) == 0;
                    end else if (el == per) begin
                        fire     = 1'b1;
                        m_act[d] = 1'b0;
                    end
                end
                if (fire) m_to[d] = 1'b1;
                else if (ack) m_to[d] = 1'b0;
            end
        end
    endfunction

    function automatic longint exp_count(input int d);
        longint el;
        longint per;
        if (!m_act[d]) return 0;
        el  = edge_n - m_t0[d];
        per = m_n[d] * m_p[d];
        if (m_ar[d]) return m_n[d] - (el % per) / m_p[d];
        return m_n[d] - el / m_p[d];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("timeout0", 32'(to0), 32'(m_to[0]));
        chk("count0", 32'(cnt0), 32'(exp_count(0)));
        chk("running0", 32'(run0), 32'(m_act[0]));
        chk("timeout1", 32'(to1), 32'(m_to[1]));
        chk("count1", 32'(cnt1), 32'(exp_count(1)));
        chk("running1", 32'(run1), 32'(m_act[1]));
    endtask

    // Apply inputs, take one edge, update the model, then compare after the edge.
    task automatic step(input bit tin, input logic [15:0] bus, input bit ack);
        timer_in  = tin;
        bus_in    = bus;
        timer_ack = ack;
        @(posedge clk);
        model_edge(tin, bus, ack);
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse asserted between edges, held over one edge.
    task automatic do_reset();
        timer_in  = 1'b0;
        bus_in    = 16'd0;
        timer_ack = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        #2;
        reset = 1'b0;
    endtask

    typedef struct {
        bit          tin;
        logic [15:0] bus;
        bit          ack;
        bit          e_to;
        logic [15:0] e_cnt;
        bit          e_run;
    } vec_t;

    vec_t tbl[13];
    int   to_seen;

    initial begin
        // Auto-reload (PRESCALE=2) sequence with hand-derived expectations.
        tbl[0]  = '{1'b1, 16'd2, 1'b0, 1'b0, 16'd2, 1'b1};
        tbl[1]  = '{1'b0, 16'd0, 1'b0, 1'b0, 16'd2, 1'b1};
        tbl[2]  = '{1'b0, 16'd0, 1'b0, 1'b0, 16'd1, 1'b1};
        tbl[3]  = '{1'b0, 16'd0, 1'b0, 1'b0, 16'd1, 1'b1};
        tbl[4]  = '{1'b0, 16'd0, 1'b0, 1'b1, 16'd2, 1'b1};
        tbl[5]  = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd2, 1'b1};
        tbl[6]  = '{1'b0, 16'd0, 1'b0, 1'b0, 16'd1, 1'b1};
        tbl[7]  = '{1'b0, 16'd0, 1'b0, 1'b0, 16'd1, 1'b1};
        tbl[8]  = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd2, 1'b1};
        tbl[9]  = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd2, 1'b1};
        tbl[10] = '{1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[11] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b0};
        tbl[12] = '{1'b1, 16'd3, 1'b1, 1'b0, 16'd3, 1'b1};

        reset     = 1'b1;
        timer_in  = 1'b0;
        bus_in    = 16'd0;
        timer_ack = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_timeout", 32'(to0), 32'd0);
        chk("reset_count", 32'(cnt0), 32'd0);
        chk("reset_running", 32'(run0), 32'd0);
        #2;
        reset = 1'b0;

        // Vector table.
        for (int k = 0; k < 13; k++) begin
            step(tbl[k].tin, tbl[k].bus, tbl[k].ack);
            chk($sformatf("tbl%0d_timeout", k), 32'(to1), 32'(tbl[k].e_to));
            chk($sformatf("tbl%0d_count", k), 32'(cnt1), 32'(tbl[k].e_cnt));
            chk($sformatf("tbl%0d_running", k), 32'(run1), 32'(tbl[k].e_run));
        end

        // One-shot load 3 with PRESCALE 12: expiry 36 edges after the load.
        do_reset();
        step(1'b1, 16'd3, 1'b0);
        for (int i = 1; i <= 36; i++) begin
            step(1'b0, 16'd0, 1'b0);
            if (i == 11) chk("oneshot_cnt_before_tick", 32'(cnt0), 32'd3);
            if (i == 12) chk("oneshot_cnt_tick1", 32'(cnt0), 32'd2);
            if (i == 24) chk("oneshot_cnt_tick2", 32'(cnt0), 32'd1);
            if (i == 35) chk("oneshot_no_early_timeout", 32'(to0), 32'd0);
            if (i == 36) begin
                chk("oneshot_timeout", 32'(to0), 32'd1);
                chk("oneshot_count_zero", 32'(cnt0), 32'd0);
                chk("oneshot_stopped", 32'(run0), 32'd0);
            end
        end
        for (int i = 0; i < 5; i++) step(1'b0, 16'd0, 1'b0);
        chk("expired_holds_timeout", 32'(to0), 32'd1);

        // Ack clears timeout, no further expiry.
        step(1'b0, 16'd0, 1'b1);
        chk("ack_clears_timeout", 32'(to0), 32'd0);
        to_seen = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 16'd0, 1'b0);
            to_seen += int'(to0);
        end
        chk("no_timeout_after_ack", 32'(to_seen), 32'd0);

        // Load collides with expiry tick: load wins.
        step(1'b1, 16'd2, 1'b0);
        for (int i = 1; i < 24; i++) step(1'b0, 16'd0, 1'b0);
        step(1'b1, 16'd5, 1'b0);
        chk("collide_timeout", 32'(to0), 32'd0);
        chk("collide_count", 32'(cnt0), 32'd5);
        chk("collide_running", 32'(run0), 32'd1);
        for (int i = 1; i < 60; i++) step(1'b0, 16'd0, 1'b0);
        chk("collide_no_early", 32'(to0), 32'd0);
        step(1'b0, 16'd0, 1'b0);
        chk("collide_expiry", 32'(to0), 32'd1);

        // Disable mid-run with load 0, then abandon mid-run with reset.
        step(1'b1, 16'd100, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, 16'd0, 1'b0);
        step(1'b1, 16'd0, 1'b0);
        chk("disable_count", 32'(cnt0), 32'd0);
        chk("disable_running", 32'(run0), 32'd0);
        to_seen = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 16'd0, 1'b0);
            to_seen += int'(to0);
        end
        chk("disable_no_timeout", 32'(to_seen), 32'd0);
        step(1'b1, 16'd100, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, 16'd0, 1'b0);
        do_reset();
        to_seen = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 16'd0, 1'b0);
            to_seen += int'(to0) + int'(run0);
        end
        chk("reset_abandon_idle", 32'(to_seen), 32'd0);
        // First edge after reset release honours a load.
        do_reset();
        step(1'b1, 16'd7, 1'b0);
        chk("post_reset_load", 32'(cnt0), 32'd7);

        // Upper boundary: full-scale load counts down without wrapping.
        step(1'b1, 16'hFFFF, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 16'd0, 1'b0);
        chk("fullscale_count", 32'(cnt0), 32'hFFFD);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          r_tin;
            bit          r_ack;
            logic [15:0] r_bus;
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                r_tin = ($urandom_range(0, 99) < 4);
                r_ack = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 9) == 0) r_bus = 16'd0;
                else if ($urandom_range(0, 49) == 0) r_bus = 16'hFFFF;
                else r_bus = 16'($urandom_range(1, 12));
                step(r_tin, r_bus, r_ack);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
